// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Data-memory access sequencer sitting between the execute stage of a
// pipelined core and a handshaking cache. An aligned load/store stalls the
// pipeline, holds a latched request on the cache port until the cache
// answers or the wait budget runs out, then releases the pipeline for one
// DONE cycle in which the instruction retires. Misaligned accesses never
// reach the cache; they only raise a one-cycle MisalignErr.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   ALUResult    byte address from execute
//   WriteData    store data from execute
//   MemRead      load request level
//   MemWrite     store request level (wins when both are high)
//   Stall        freezes PC / pipeline registers while high
//   ReadData     last completed load result (0 after a timed-out load)
//   MisalignErr  combinational flag for a misaligned access in IDLE
//   BusErr       high during the DONE cycle that follows a timeout
//   CacheReq     cache request, high exactly while waiting
//   CacheWe      1 = write, 0 = read
//   CacheAddr    latched word address
//   CacheWData   latched store data
//   CacheReady   cache completion, only looked at while waiting
//   CacheRData   cache read data, valid with CacheReady
//
// Parameters
//   TIMEOUT      maximum number of wait cycles before a bus error
//   CNT_W        timeout counter width, 2**CNT_W must exceed TIMEOUT
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access in flight; accepts a new aligned request
// WAIT   | request presented to the cache, counting wait cycles
// DONE   | access finished (ok or timed out); pipeline released
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic        CacheReq,
    output logic        CacheWe,
    output logic [31:0] CacheAddr,
    output logic [31:0] CacheWData,
    input  logic        CacheReady,
    input  logic [31:0] CacheRData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      read_data;
    logic             cache_we;
    logic [31:0]      cache_addr;
    logic [31:0]      cache_wdata;
    logic             bus_err;

    logic             access;
    logic             aligned;
    logic             stall;
    logic             misalign_err;
    logic             cache_req;
    logic             latch_en;
    logic             timeout_hit;

    assign access  = MemRead | MemWrite;
    assign aligned = (ALUResult[1:0] == 2'b00);

    // -------------------------------------------------------------------------
    // Next state and combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        misalign_err = 1'b0;
        cache_req    = 1'b0;
        latch_en     = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (access && aligned) begin
                    stall     = 1'b1;
                    latch_en  = 1'b1;
                    state_nxt = S_WAIT;
                end else if (access) begin
                    misalign_err = 1'b1;
                end
            end
            S_WAIT: begin
                stall     = 1'b1;
                cache_req = 1'b1;
                // A completion in the last allowed cycle still counts as a
                // success: CacheReady is tested before the timeout compare.
                if (CacheReady) begin
                    state_nxt = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                // The instruction retires here; requests are not accepted
                // until the following IDLE cycle.
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            read_data   <= '0;
            cache_we    <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            bus_err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bus_err <= timeout_hit;

            if (latch_en) begin
                cache_addr  <= {ALUResult[31:2], 2'b00};
                cache_wdata <= WriteData;
                cache_we    <= MemWrite;
                cnt         <= '0;
            end else if (state == S_WAIT && !CacheReady) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state == S_WAIT && !cache_we) begin
                if (CacheReady) begin
                    read_data <= CacheRData;
                end else if (timeout_hit) begin
                    read_data <= '0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs; request and error flag are forced low while reset is held so
    // an access caught mid-WAIT is withdrawn immediately.
    // -------------------------------------------------------------------------
    assign Stall       = stall;
    assign MisalignErr = misalign_err & ~rst;
    assign CacheReq    = cache_req & ~rst;
    assign CacheWe     = cache_we;
    assign CacheAddr   = cache_addr;
    assign CacheWData  = cache_wdata;
    assign ReadData    = read_data;
    assign BusErr      = bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic        Stall;
    logic [31:0] ReadData;
    logic        MisalignErr;
    logic        BusErr;
    logic        CacheReq;
    logic        CacheWe;
    logic [31:0] CacheAddr;
    logic [31:0] CacheWData;
    logic        CacheReady;
    logic [31:0] CacheRData;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_rd;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Stall      (Stall),
        .ReadData   (ReadData),
        .MisalignErr(MisalignErr),
        .BusErr     (BusErr),
        .CacheReq   (CacheReq),
        .CacheWe    (CacheWe),
        .CacheAddr  (CacheAddr),
        .CacheWData (CacheWData),
        .CacheReady (CacheReady),
        .CacheRData (CacheRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle: no access, cache noise on CacheReady must be ignored.
    task automatic do_idle();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUResult  = $urandom;
        CacheReady = 1'($urandom % 2);
        CacheRData = $urandom;
        #1;
        check("idle_stall", 32'(Stall), 32'd0);
        check("idle_req", 32'(CacheReq), 32'd0);
        check("idle_merr", 32'(MisalignErr), 32'd0);
        check("idle_rdata", ReadData, exp_rd);
        step();
    endtask

    // Misaligned access: flagged for the cycle, no request, no stall.
    task automatic do_misalign(input logic [31:0] addr, input bit rd, input bit wr);
        ALUResult  = addr;
        WriteData  = $urandom;
        MemRead    = rd;
        MemWrite   = wr;
        CacheReady = 1'($urandom % 2);
        #1;
        check("mis_flag", 32'(MisalignErr), 32'd1);
        check("mis_stall", 32'(Stall), 32'd0);
        check("mis_req", 32'(CacheReq), 32'd0);
        step();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #1;
        check("mis_flag_clr", 32'(MisalignErr), 32'd0);
        check("mis_req_after", 32'(CacheReq), 32'd0);
        check("mis_rdata", ReadData, exp_rd);
        step();
    endtask

    // Aligned access. d = WAIT cycle (1-based) in which the cache answers;
    // d > TIMEOUT means it never answers. rst_at != 0 asserts reset during
    // that WAIT cycle instead of completing.
    task automatic do_access(input bit is_write, input bit both, input logic [31:0] addr,
                             input logic [31:0] wd, input int d, input logic [31:0] rdv,
                             input int rst_at);
        int  nwait;
        bit  tmo;
        tmo   = (d > TIMEOUT);
        nwait = tmo ? TIMEOUT : d;

        ALUResult  = addr;
        WriteData  = wd;
        MemWrite   = is_write;
        MemRead    = !is_write || both;
        CacheReady = 1'($urandom % 2);
        CacheRData = $urandom;
        #1;
        check("t0_stall", 32'(Stall), 32'd1);
        check("t0_req", 32'(CacheReq), 32'd0);
        check("t0_merr", 32'(MisalignErr), 32'd0);
        step();

        for (int k = 1; k <= nwait; k++) begin
            // Execute-stage values wander; the cache side must not.
            ALUResult = $urandom;
            WriteData = $urandom;
            if (rst_at == k) begin
                rst        = 1'b1;
                CacheReady = 1'($urandom % 2);
                CacheRData = $urandom;
                #1;
                check("rst_req_drop", 32'(CacheReq), 32'd0);
                step();
                rst        = 1'b0;
                MemRead    = 1'b0;
                MemWrite   = 1'b0;
                CacheReady = 1'b0;
                exp_rd     = 32'd0;
                #1;
                check("rst_stall", 32'(Stall), 32'd0);
                check("rst_req", 32'(CacheReq), 32'd0);
                check("rst_rdata", ReadData, exp_rd);
                check("rst_buserr", 32'(BusErr), 32'd0);
                check("rst_addr", CacheAddr, 32'd0);
                step();
                return;
            end
            CacheReady = (k == d);
            CacheRData = (k == d) ? rdv : $urandom;
            #1;
            check("w_req", 32'(CacheReq), 32'd1);
            check("w_stall", 32'(Stall), 32'd1);
            check("w_addr", CacheAddr, addr);
            check("w_wdata", CacheWData, wd);
            check("w_we", 32'(CacheWe), 32'(is_write));
            check("w_rdata", ReadData, exp_rd);
            check("w_buserr", 32'(BusErr), 32'd0);
            step();
        end

        if (!is_write) exp_rd = tmo ? 32'd0 : rdv;

        // DONE: inputs are ignored, including a misaligned request.
        MemRead    = 1'($urandom % 2);
        MemWrite   = 1'($urandom % 2);
        ALUResult  = $urandom;
        CacheReady = 1'($urandom % 2);
        CacheRData = $urandom;
        #1;
        check("d_stall", 32'(Stall), 32'd0);
        check("d_req", 32'(CacheReq), 32'd0);
        check("d_merr", 32'(MisalignErr), 32'd0);
        check("d_buserr", 32'(BusErr), 32'(tmo));
        check("d_rdata", ReadData, exp_rd);
        step();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        CacheReady = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        n_tests    = 0;
        n_fail     = 0;
        exp_rd     = 32'd0;
        rst        = 1'b1;
        ALUResult  = 32'h0000_0102;
        WriteData  = 32'hFFFF_FFFF;
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        CacheReady = 1'b1;
        CacheRData = 32'hFFFF_FFFF;
        step();
        step();
        check("rst_rdata0", ReadData, 32'd0);
        check("rst_caddr0", CacheAddr, 32'd0);
        check("rst_cwdata0", CacheWData, 32'd0);
        check("rst_cwe0", 32'(CacheWe), 32'd0);
        check("rst_buserr0", 32'(BusErr), 32'd0);
        check("rst_req0", 32'(CacheReq), 32'd0);
        check("rst_merr0", 32'(MisalignErr), 32'd0);
        rst        = 1'b0;
        MemRead    = 1'b0;
        CacheReady = 1'b0;
        do_idle();

        // Aligned read, answered in the first WAIT cycle.
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
        // Write, answered in the third WAIT cycle; ReadData keeps 0xDEADBEEF.
        do_access(1'b1, 1'b0, 32'h20, 32'h12345678, 3, 32'hAAAA5555, 0);
        // Misaligned read.
        do_misalign(32'h102, 1'b1, 1'b0);
        // Read timeout.
        do_access(1'b0, 1'b0, 32'h200, 32'h0, TIMEOUT + 1, 32'h0, 0);
        // Ready in the very last allowed cycle beats the timeout.
        do_access(1'b0, 1'b0, 32'h204, 32'h0, TIMEOUT, 32'hCAFEF00D, 0);
        // Write timeout leaves ReadData alone.
        do_access(1'b1, 1'b0, 32'h208, 32'h55, TIMEOUT + 2, 32'h0, 0);
        // Read+Write together is a write.
        do_access(1'b1, 1'b1, 32'h30, 32'h0BAD0BAD, 2, 32'h1111_1111, 0);
        // Reset in the second WAIT cycle.
        do_access(1'b0, 1'b0, 32'h40, 32'h0, 3, 32'h7777_7777, 2);
        // Back-to-back reads.
        do_access(1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h0000_1234, 0);
        do_access(1'b0, 1'b0, 32'h4, 32'h0, 2, 32'h0000_5678, 0);

        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if (kind == 0) begin
                do_idle();
            end else if (kind == 1) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
                do_misalign(a, 1'($urandom % 2), 1'b1);
            end else if (kind == 2) begin
                a[1:0] = 2'b00;
                do_access(1'($urandom % 2), 1'($urandom % 2), a, $urandom,
                          3, $urandom, $urandom_range(1, 3));
            end else begin
                a[1:0] = 2'b00;
                do_access(1'($urandom % 2), 1'($urandom % 2), a, $urandom,
                          $urandom_range(1, TIMEOUT + 2), $urandom, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before a bus error.
REQ-002 SHALL have parameter CNT_W, default 7, meaning the timeout counter width (must satisfy 2^CNT_W > TIMEOUT).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port ALUResult, input, 32, the byte address computed by the execute stage.
REQ-006 SHALL have port WriteData, input, 32, the store data.
REQ-007 SHALL have port MemRead, input, 1, the load request level from control.
REQ-008 SHALL have port MemWrite, input, 1, the store request level from control.
REQ-009 SHALL have port Stall, output, 1, which freezes PC and pipeline registers while high.
REQ-010 SHALL have port ReadData, output, 32, the load result.
REQ-011 SHALL have port MisalignErr, output, 1, a one-cycle misaligned-access flag.
REQ-012 SHALL have port BusErr, output, 1, a one-cycle timeout flag.
REQ-013 SHALL have port CacheReq, output, 1, the cache request, held until accepted.
REQ-014 SHALL have port CacheWe, output, 1, where 1 = write and 0 = read.
REQ-015 SHALL have port CacheAddr, output, 32, the latched word address (bits [1:0] = 00).
REQ-016 SHALL have port CacheWData, output, 32, the latched store data.
REQ-017 SHALL have port CacheReady, input, 1, the cache completion; meaningful only while CacheReq = 1.
REQ-018 SHALL have port CacheRData, input, 32, the cache read data, valid when CacheReady = 1.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, and DONE.
REQ-020 SHALL define access = MemRead | MemWrite and aligned = (ALUResult[1:0] == 2'b00).
REQ-021 SHALL, in IDLE with access & aligned: latch ALUResult, WriteData, and CacheWe = MemWrite, then go to WAIT.
REQ-022 SHALL treat MemRead & MemWrite both high as a write.
REQ-023 SHALL, in IDLE with access & !aligned: issue no cache request, pulse MisalignErr for that cycle (combinational), hold Stall = 0, leave ReadData unchanged, and stay in IDLE.
REQ-024 SHALL drive Stall combinationally as (IDLE & access & aligned) | WAIT, and low in DONE.
REQ-025 SHALL drive CacheReq = 1 exactly while in WAIT, with CacheAddr, CacheWData, and CacheWe stable throughout WAIT.
REQ-026 SHALL, in WAIT with CacheReady = 1, go to DONE; for a read, register CacheRData into ReadData at that edge.
REQ-027 SHALL clear the timeout counter on entry to WAIT and increment it each WAIT cycle without CacheReady.
REQ-028 SHALL, when the counter reaches TIMEOUT - 1 without CacheReady: go to DONE, set BusErr = 1 during DONE, and (for a read) set ReadData = 0.
REQ-029 SHALL give CacheReady priority over timeout when both occur in the same cycle (no BusErr).
REQ-030 SHALL, in DONE, always go to IDLE next cycle and ignore MemRead/MemWrite, because the instruction retires this cycle; a back-to-back access is accepted in the following IDLE cycle.
REQ-031 SHALL ignore CacheReady in IDLE and DONE.
REQ-032 SHALL hold ReadData until the next completed read or timed-out read; writes do not alter ReadData.
REQ-033 SHALL have latency: request cycle T0 (IDLE, Stall = 1), T1 WAIT (CacheReq = 1); with ready at T1, DONE at T2 (Stall = 0, ReadData valid); minimum 2 stall cycles.

Reset
REQ-034 SHALL, when rst = 1 at a clock edge, set state = IDLE, counter = 0, ReadData = 0, CacheWe = 0, CacheAddr = 0, CacheWData = 0, and BusErr = 0.
REQ-035 SHALL hold CacheReq = 0 and MisalignErr = 0 while rst is high.
REQ-036 SHALL, on reset asserted in WAIT, drop CacheReq at the next edge and discard the pending access without a ReadData update.

Verification
REQ-037 SHALL test an aligned read: ALUResult = 0x100, MemRead = 1, CacheReady high at T1 with CacheRData = 0xDEADBEEF -> Stall high at T0 and T1, CacheAddr = 0x100, CacheWe = 0, ReadData = 0xDEADBEEF at T2 with Stall = 0.
REQ-038 SHALL test a write with 3 wait cycles: ALUResult = 0x20, WriteData = 0x12345678, MemWrite = 1, CacheReady at the 3rd WAIT cycle -> CacheReq high for 3 cycles with stable data, CacheWe = 1, ReadData unchanged.
REQ-039 SHALL test a misaligned access: ALUResult = 0x102, MemRead = 1 -> MisalignErr = 1 for one cycle, Stall = 0, CacheReq never asserted.
REQ-040 SHALL test a timeout with TIMEOUT = 4: read with CacheReady held low -> 4 WAIT cycles, then DONE with BusErr = 1 and ReadData = 0.
REQ-041 SHALL test reset mid-WAIT: rst = 1 during the 2nd WAIT cycle -> next edge IDLE, CacheReq = 0, ReadData = 0.
REQ-042 SHALL test back-to-back reads at 0x0 then 0x4 -> DONE, IDLE, and new WAIT sequence, with CacheAddr = 0x4 in the second WAIT.
